// File: rtl/pic_bus_master.sv
// rtl/pic_bus_master.sv - 8259A CPU-side bus initiator: ICW sequencing, OCW writes, status reads
module pic_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_req,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       ocw_req,
    input  logic [1:0] ocw_sel,
    input  logic [7:0] ocw_data,
    input  logic       rd_req,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in
);
    localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAX_CYC = (STROBE_CYC > MAX_SH) ? STROBE_CYC : MAX_SH;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;
    typedef enum logic [1:0] {OP_INIT, OP_OCW, OP_RD} op_t;

    state_t        state_q, state_d;
    op_t           op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    step_q, step_d;
    logic          a0_q, a0_d;
    logic [7:0]    dout_q, dout_d;
    logic          initialized_q, init_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [7:0]    rd_shadow_q, shadow_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rd_valid_q, rd_valid_d;
    logic          icw_ld;
    logic          sngl_q, ic4_q;
    logic [7:0]    icw2_q, icw3_q, icw4_q;
    logic [2:0]    nxt;
    logic [7:0]    icw_next_data;

    // Returns {more, step}: step 1=ICW2, 2=ICW3, 3=ICW4.
    function automatic logic [2:0] next_step(input logic [1:0] cur, input logic sngl,
                                             input logic ic4);
        logic [2:0] r;
        r = 3'b000;
        case (cur)
            2'd0:    r = {1'b1, 2'd1};
            2'd1:    r = !sngl ? {1'b1, 2'd2} : (ic4 ? {1'b1, 2'd3} : 3'b000);
            2'd2:    r = ic4 ? {1'b1, 2'd3} : 3'b000;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    always_comb begin
        nxt = next_step(step_q, sngl_q, ic4_q);
        case (nxt[1:0])
            2'd1:    icw_next_data = icw2_q;
            2'd2:    icw_next_data = icw3_q;
            default: icw_next_data = icw4_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        a0_d       = a0_q;
        dout_d     = dout_q;
        init_d     = initialized_q;
        rd_data_d  = rd_data_q;
        shadow_d   = rd_shadow_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rd_valid_d = 1'b0;
        icw_ld     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (init_req) begin
                    op_d    = OP_INIT;
                    icw_ld  = 1'b1;
                    step_d  = 2'd0;
                    a0_d    = 1'b0;
                    dout_d  = icw1 | 8'h10;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end else if (ocw_req) begin
                    if (!initialized_q || ocw_sel == 2'd0) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = OP_OCW;
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                        case (ocw_sel)
                            2'd1: begin a0_d = 1'b1; dout_d = ocw_data; end
                            2'd2: begin a0_d = 1'b0; dout_d = ocw_data & 8'hE7; end
                            default: begin a0_d = 1'b0; dout_d = (ocw_data & 8'hE7) | 8'h08; end
                        endcase
                    end
                end else if (rd_req) begin
                    op_d    = OP_RD;
                    a0_d    = 1'b0;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    if (op_q == OP_RD) shadow_d = d_in;
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) state_d = S_GAP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_GAP: begin
                // Bus address/data only move here, while cs_n is high.
                if (op_q == OP_INIT && nxt[2]) begin
                    step_d  = nxt[1:0];
                    a0_d    = 1'b1;
                    dout_d  = icw_next_data;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end else begin
                    state_d = S_IDLE;
                    if (op_q == OP_RD) begin
                        rd_data_d  = rd_shadow_q;
                        rd_valid_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (op_q == OP_INIT) init_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= OP_INIT;
            cnt_q         <= '0;
            step_q        <= 2'd0;
            a0_q          <= 1'b0;
            dout_q        <= 8'h00;
            initialized_q <= 1'b0;
            rd_data_q     <= 8'h00;
            rd_shadow_q   <= 8'h00;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            rd_valid_q    <= 1'b0;
            sngl_q        <= 1'b0;
            ic4_q         <= 1'b0;
            icw2_q        <= 8'h00;
            icw3_q        <= 8'h00;
            icw4_q        <= 8'h00;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            step_q        <= step_d;
            a0_q          <= a0_d;
            dout_q        <= dout_d;
            initialized_q <= init_d;
            rd_data_q     <= rd_data_d;
            rd_shadow_q   <= shadow_d;
            done_q        <= done_d;
            err_q         <= err_d;
            rd_valid_q    <= rd_valid_d;
            if (icw_ld) begin
                sngl_q <= icw1[1];
                ic4_q  <= icw1[0];
                icw2_q <= icw2;
                icw3_q <= icw3;
                icw4_q <= icw4;
            end
        end
    end

    logic bus_active;
    assign bus_active = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign cs_n     = !bus_active;
    assign wr_n     = !(state_q == S_STROBE && op_q != OP_RD);
    assign rd_n     = !(state_q == S_STROBE && op_q == OP_RD);
    assign d_oe     = bus_active && (op_q != OP_RD);
    assign a0       = a0_q;
    assign d_out    = dout_q;
endmodule

// File: tb/tb_pic_bus_master.sv
// tb/tb_pic_bus_master.sv - self-checking bench for pic_bus_master
module tb_pic_bus_master;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_req = 1'b0, ocw_req = 1'b0, rd_req = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
    logic [1:0] ocw_sel = 2'd0;
    logic [7:0] ocw_data = 8'h00, d_in = 8'h00;
    logic       busy, done, err, rd_valid, cs_n, wr_n, rd_n, a0, d_oe;
    logic [7:0] rd_data, d_out;

    always #5 clk = ~clk;

    pic_bus_master dut (
        .clk(clk), .rst_n(rst_n), .init_req(init_req),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .ocw_req(ocw_req), .ocw_sel(ocw_sel), .ocw_data(ocw_data), .rd_req(rd_req),
        .busy(busy), .done(done), .err(err), .rd_data(rd_data), .rd_valid(rd_valid),
        .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0), .d_out(d_out), .d_oe(d_oe),
        .d_in(d_in)
    );

    typedef enum int {K_INIT, K_OCW, K_RD} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] i1, i2, i3, i4;
        logic [1:0] sel;
        logic [7:0] data;
        logic [7:0] din;
        logic       exp_err;
        int         exp_lat;
    } vec_t;
    typedef struct packed {
        logic       is_rd;
        logic       a0;
        logic [7:0] data;
    } bus_t;

    bus_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(kind_e k, logic [7:0] i1, logic [7:0] i2, logic [7:0] i3,
                                logic [7:0] i4, logic [1:0] sel, logic [7:0] data,
                                logic [7:0] din, logic e, int lat);
        vec_t v;
        v.kind = k; v.i1 = i1; v.i2 = i2; v.i3 = i3; v.i4 = i4;
        v.sel = sel; v.data = data; v.din = din; v.exp_err = e; v.exp_lat = lat;
        return v;
    endfunction

    // Reference model of the bus cycles each accepted request should produce.
    task automatic push_expected(input vec_t v);
        if (v.exp_err) return;
        case (v.kind)
            K_INIT: begin
                exp_q.push_back({1'b0, 1'b0, v.i1 | 8'h10});
                exp_q.push_back({1'b0, 1'b1, v.i2});
                if (v.i1[1] == 1'b0) exp_q.push_back({1'b0, 1'b1, v.i3});
                if (v.i1[0] == 1'b1) exp_q.push_back({1'b0, 1'b1, v.i4});
            end
            K_OCW: begin
                if (v.sel == 2'd1)      exp_q.push_back({1'b0, 1'b1, v.data});
                else if (v.sel == 2'd2) exp_q.push_back({1'b0, 1'b0, v.data & 8'hE7});
                else                    exp_q.push_back({1'b0, 1'b0, (v.data & 8'hE7) | 8'h08});
            end
            default: exp_q.push_back({1'b1, 1'b0, 8'h00});
        endcase
    endtask

    logic       prev_wr = 1'b1, prev_rd = 1'b1, prev_cs = 1'b1, prev_a0 = 1'b0;
    logic [7:0] prev_d = 8'h00;
    int         low_cnt = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if ((!wr_n && prev_wr) || (!rd_n && prev_rd)) begin
                bus_t e;
                check("strobe_setup_stable", {prev_cs, prev_a0, prev_d}, {cs_n, a0, d_out});
                check("bus_cycle_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("bus_cycle", {!rd_n, a0, (rd_n ? d_out : 8'h00), d_oe, cs_n},
                          {e.is_rd, e.a0, e.data, !e.is_rd, 1'b0});
                end
            end
            if (!wr_n || !rd_n) low_cnt++;
            else if (low_cnt != 0) begin
                check("strobe_width", low_cnt, 2);
                low_cnt = 0;
            end
        end else begin
            low_cnt = 0;
        end
        prev_wr = wr_n; prev_rd = rd_n; prev_cs = cs_n; prev_a0 = a0; prev_d = d_out;
    end

    // Called at a negedge; drives one request, waits for its response at later negedges.
    task automatic run_vec(input vec_t v);
        int   n;
        logic fin, saw_cs, oe_bad, exp_done, exp_rdv;
        push_expected(v);
        init_req = (v.kind == K_INIT);
        ocw_req  = (v.kind == K_OCW);
        rd_req   = (v.kind == K_RD);
        icw1 = v.i1; icw2 = v.i2; icw3 = v.i3; icw4 = v.i4;
        ocw_sel = v.sel; ocw_data = v.data; d_in = v.din;
        @(posedge clk);
        @(negedge clk);
        init_req = 1'b0; ocw_req = 1'b0; rd_req = 1'b0;
        check("busy_after_accept", busy, !v.exp_err);
        n = 1; fin = 1'b0; saw_cs = 1'b0; oe_bad = 1'b0;
        while (!fin && n <= 60) begin
            if (!cs_n) saw_cs = 1'b1;
            if (v.kind == K_RD && d_oe) oe_bad = 1'b1;
            if (done || err || rd_valid) fin = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        exp_done = !v.exp_err && (v.kind != K_RD);
        exp_rdv  = !v.exp_err && (v.kind == K_RD);
        check("latency", n, v.exp_lat);
        check("response_flags", {done, err, rd_valid, busy}, {exp_done, v.exp_err, exp_rdv, 1'b0});
        if (v.kind == K_RD) begin
            check("rd_data", rd_data, v.din);
            check("rd_d_oe_low", oe_bad, 1'b0);
        end
        if (v.exp_err) check("no_bus_on_err", saw_cs, 1'b0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    vec_t vecs[11];

    initial begin
        int   n;
        logic saw_other, busy_seen;
        vec_t va;

        vecs[0]  = mk(K_OCW,  8'h00, 8'h00, 8'h00, 8'h00, 2'd2, 8'h11, 8'h00, 1'b1, 1);
        vecs[1]  = mk(K_RD,   8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 8'h5A, 1'b0, 6);
        vecs[2]  = mk(K_INIT, 8'h13, 8'h20, 8'hAA, 8'h01, 2'd0, 8'h00, 8'h00, 1'b0, 16);
        vecs[3]  = mk(K_INIT, 8'h00, 8'h08, 8'h04, 8'h77, 2'd0, 8'h00, 8'h00, 1'b0, 16);
        vecs[4]  = mk(K_INIT, 8'h01, 8'h30, 8'h02, 8'h03, 2'd0, 8'h00, 8'h00, 1'b0, 21);
        vecs[5]  = mk(K_INIT, 8'h02, 8'h40, 8'h66, 8'h99, 2'd0, 8'h00, 8'h00, 1'b0, 11);
        vecs[6]  = mk(K_OCW,  8'h00, 8'h00, 8'h00, 8'h00, 2'd2, 8'hFF, 8'h00, 1'b0, 6);
        vecs[7]  = mk(K_OCW,  8'h00, 8'h00, 8'h00, 8'h00, 2'd3, 8'h02, 8'h00, 1'b0, 6);
        vecs[8]  = mk(K_OCW,  8'h00, 8'h00, 8'h00, 8'h00, 2'd1, 8'h5C, 8'h00, 1'b0, 6);
        vecs[9]  = mk(K_OCW,  8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h5C, 8'h00, 1'b1, 1);
        vecs[10] = mk(K_RD,   8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 8'hC3, 1'b0, 6);

        repeat (2) @(negedge clk);
        check("reset_strobes", {cs_n, wr_n, rd_n}, 3'b111);
        check("reset_bus", {a0, d_out, d_oe}, 10'h000);
        check("reset_status", {busy, done, err, rd_valid, rd_data}, 12'h000);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // All three requests together: only init runs; a later init while busy is dropped.
        va = mk(K_INIT, 8'h13, 8'h20, 8'hAA, 8'h01, 2'd0, 8'h00, 8'h00, 1'b0, 16);
        push_expected(va);
        init_req = 1'b1; ocw_req = 1'b1; rd_req = 1'b1;
        icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'hAA; icw4 = 8'h01;
        ocw_sel = 2'd1; ocw_data = 8'h44; d_in = 8'h99;
        @(posedge clk);
        @(negedge clk);
        init_req = 1'b0; ocw_req = 1'b0; rd_req = 1'b0;
        n = 1; saw_other = 1'b0;
        while (!done && n <= 60) begin
            if (err || rd_valid) saw_other = 1'b1;
            if (n == 3) begin init_req = 1'b1; icw1 = 8'h01; icw2 = 8'h55; end
            else init_req = 1'b0;
            @(negedge clk);
            n++;
        end
        init_req = 1'b0;
        check("prio_latency", n, 16);
        check("prio_no_other_resp", saw_other, 1'b0);
        busy_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy || err || rd_valid) busy_seen = 1'b1;
        end
        check("busy_req_dropped", busy_seen, 1'b0);
        check("prio_queue_drained", exp_q.size(), 0);

        // Reset during ICW2 strobe.
        exp_q.push_back({1'b0, 1'b0, 8'h13});
        exp_q.push_back({1'b0, 1'b1, 8'h20});
        init_req = 1'b1; icw1 = 8'h13; icw2 = 8'h20; icw4 = 8'h01;
        @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        repeat (6) @(negedge clk);
        check("icw2_strobe_active", {wr_n, a0, d_out}, {1'b0, 1'b1, 8'h20});
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_bus", {cs_n, wr_n, rd_n, d_oe, busy}, 5'b11100);
        check("reset_mid_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(mk(K_OCW, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1, 8'h5C, 8'h00, 1'b1, 1));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pic_bus_master.md
# pic_bus_master

CPU-side bus initiator for the 8259A PIC model. It turns single-cycle requests (initialise, write OCW, read status) into correctly ordered and timed CS/WR/RD/A0/data bus cycles toward the PIC's read/write logic. It also decides which ICWs the sequence needs, from ICW1 bits 1 (SNGL) and 0 (IC4). It sits between a testbench or CPU model and the PIC top level.

## Interface
Parameters:
- SETUP_CYC, 1: cycles `cs_n`/`a0`/data are valid before the strobe falls (≥1).
- STROBE_CYC, 2: strobe low width in cycles (≥1).
- HOLD_CYC, 1: cycles `cs_n`/`a0`/data are held after the strobe rises (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- init_req  in  1  start the ICW sequence.
- icw1, icw2, icw3, icw4  in  8 each  ICW values, captured on acceptance.
- ocw_req  in  1  write one OCW.
- ocw_sel  in  2  OCW selector: 1, 2 or 3; 0 is illegal.
- ocw_data  in  8  OCW value.
- rd_req  in  1  perform one status read cycle.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse when a write request completes.
- err  out  1  one-cycle pulse when a request is rejected.
- rd_data  out  8  last captured read value.
- rd_valid  out  1  one-cycle pulse when `rd_data` updates.
- cs_n, wr_n, rd_n  out  1 each  PIC bus strobes, active-low.
- a0  out  1  PIC address bit.
- d_out  out  8  write data.
- d_oe  out  1  data bus drive enable.
- d_in  in  8  read data from the PIC.

## Operation
- Acceptance:
  - Requests are sampled only on an edge where `busy`=0; requests seen while busy are dropped.
  - Priority when several are high together: init_req > ocw_req > rd_req.
  - All request inputs are captured at acceptance.
- Init sequence:
  - ICW1 is written with A0=0, and bit 4 is forced to 1 on the bus.
  - ICW2 is written with A0=1.
  - ICW3 is written with A0=1, only if `icw1[1]`=0.
  - ICW4 is written with A0=1, only if `icw1[0]`=1.
  - After the last write, the internal `initialized` flag is set.
- OCW writes, all rejected (err pulse, no bus cycle) if `initialized`=0 or `ocw_sel`=0:
  - OCW1: A0=1, data as given.
  - OCW2: A0=0, data with bits [4:3] forced to 00.
  - OCW3: A0=0, data with bits [4:3] forced to 01.
- Reads:
  - One read cycle with A0=0; `d_oe`=0 throughout.
  - `d_in` is captured on the last STROBE cycle.
  - Reads are allowed before init.
- FSM: IDLE → SETUP → STROBE → HOLD → GAP, then back to SETUP for the next ICW, or to IDLE.
  - A single down-counter sized for the largest parameter times each phase.
  - A step register tracks the ICW index.
- Bus levels by phase:
  - SETUP: `cs_n`=0, strobes high, `d_oe`=1 for writes.
  - STROBE: `wr_n` or `rd_n` low.
  - HOLD: strobe high, `cs_n`, `a0` and data unchanged.
  - GAP: one cycle with `cs_n`=1 and `d_oe`=0.
- Reset values (applied asynchronously):
  - `cs_n`, `wr_n`, `rd_n` = 1.
  - `a0`, `d_out`, `d_oe` = 0.
  - `busy`, `done`, `err`, `rd_valid` = 0; `rd_data` = 0x00.
  - `initialized` = 0.

## Timing
- Bus cycle length: C = SETUP_CYC + STROBE_CYC + HOLD_CYC + 1; C = 5 with defaults.
- Request accepted at edge k:
  - `busy`=1 and the first SETUP cycle start at k+1.
  - `err` pulses at k+1 instead, with `busy` staying 0.
- Completion of an N-write request:
  - `done`=1 and `busy`=0 together in cycle k+1+N·C.
  - A new request may be accepted at that same edge.
- Read completion: `rd_valid`=1, `busy`=0 and `rd_data` updated together in cycle k+1+C.
- Stability: `wr_n` and `rd_n` never fall in the same cycle that `cs_n`, `a0` or `d_out` change.
- Reset mid-operation: bus outputs go inactive immediately, the partial sequence is abandoned and `initialized` is cleared. There is no resume.

## Test plan
- init_req with icw1=0x13, icw2=0x20, icw4=0x01 → 3 writes, A0 = 0,1,1, data 0x13,0x20,0x01; no ICW3; `done` 16 cycles after acceptance.
- init_req with icw1=0x00, icw2=0x08, icw3=0x04 → 3 writes, data 0x10,0x08,0x04; a second init with icw1=0x01, icw3=0x02 → 4 writes, data 0x11, icw2, 0x02, icw4.
- ocw_req with sel=2 before any init → `err` pulse, `cs_n` stays 1. After init: sel=2, data 0xFF → A0=0, bus 0xE7; sel=3, data 0x02 → bus 0x0A; sel=1, data 0x5C → A0=1, bus 0x5C.
- rd_req with d_in=0x5A → `rd_n` low exactly 2 cycles, `d_oe`=0 throughout, `rd_data`=0x5A and `rd_valid` pulse 6 cycles after acceptance.
- init_req, ocw_req and rd_req all high in one cycle → only init runs; a further init_req raised while busy → ignored.
- rst_n low during ICW2 STROBE → `wr_n`/`cs_n` high immediately; after release, ocw_req with sel=1 → `err` pulse.
